// File: rtl/lsu_dcache_port_pkg.sv
// ---------------------------------------------------------------------------
// lsu_dcache_port_pkg
// Shared encodings for the load/store unit dcache port:
//   - load type codes (LD_NONE..LD_LHU) as carried by IDEX_LdType
//   - store type codes (ST_NONE..ST_SW) as carried by IDEX_StType
//   - LSU FSM state encoding (2 bits)
//   - is_load helper (codes 6/7 are treated as "no load")
// ---------------------------------------------------------------------------
package lsu_dcache_port_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [2:0] t);
    return (t >= LD_LB) && (t <= LD_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane helper for the LSU.
//   Request side (from the EX stage operands):
//     i_off, i_ld_type, i_st_type, i_st_data -> o_wdata, o_wstrb, o_misalign
//   Response side (from the latched access):
//     i_rsp_off, i_rsp_ld_type, i_rdata      -> o_ld_data
// The caller masks i_st_type to ST_NONE when the access is a load, so a
// load never produces byte enables.
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_dcache_port_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_off,
  input  logic [2:0]        i_ld_type,
  input  logic [1:0]        i_st_type,
  input  logic [DATA_W-1:0] i_st_data,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_misalign,
  input  logic [1:0]        i_rsp_off,
  input  logic [2:0]        i_rsp_ld_type,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [DATA_W-1:0] w_shift;

  // Load type wins over store type when both are nonzero.
  always_comb begin
    o_misalign = 1'b0;
    if (is_load(i_ld_type)) begin
      case (i_ld_type)
        LD_LH, LD_LHU: o_misalign = i_off[0];
        LD_LW:         o_misalign = (i_off != 2'b00);
        default:       o_misalign = 1'b0;
      endcase
    end else begin
      case (i_st_type)
        ST_SH:   o_misalign = i_off[0];
        ST_SW:   o_misalign = (i_off != 2'b00);
        default: o_misalign = 1'b0;
      endcase
    end
  end

  // Data is replicated across lanes so the cache can take any lane
  // selected by the strobe without its own shifter.
  always_comb begin
    o_wdata = '0;
    o_wstrb = 4'b0000;
    case (i_st_type)
      ST_SB: begin
        o_wdata = {4{i_st_data[7:0]}};
        o_wstrb = 4'b0001 << i_off;
      end
      ST_SH: begin
        o_wdata = {2{i_st_data[15:0]}};
        o_wstrb = 4'b0011 << {i_off[1], 1'b0};
      end
      ST_SW: begin
        o_wdata = i_st_data;
        o_wstrb = 4'b1111;
      end
      default: begin
        o_wdata = '0;
        o_wstrb = 4'b0000;
      end
    endcase
  end

  assign w_shift = i_rdata >> {i_rsp_off, 3'b000};

  always_comb begin
    o_ld_data = '0;
    case (i_rsp_ld_type)
      LD_LB:   o_ld_data = {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
      LD_LH:   o_ld_data = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
      LD_LW:   o_ld_data = w_shift;
      LD_LBU:  o_ld_data = {{(DATA_W-8){1'b0}}, w_shift[7:0]};
      LD_LHU:  o_ld_data = {{(DATA_W-16){1'b0}}, w_shift[15:0]};
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dcache_port.sv
// ---------------------------------------------------------------------------
// lsu_dcache_port
// Memory-side consumer of the EX result bus. Issues one valid/ready dcache
// request per load/store, waits for load data, extends it, and stalls the
// front of the pipe while the access is outstanding.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   ex_valid, EX_LdStFlag         EX holds a valid memory instruction
//   EX_AluData, st_data           effective address, store data
//   IDEX_LdType, IDEX_StType      access type codes
//   dc_req_*                      request channel to the dcache
//   dc_resp_valid, dc_resp_rdata  load response from the dcache
//   lsu_stall                     hold IF/ID/EX
//   wb_valid, wb_data             one-cycle load result to MEM/WB
//   lsu_misalign                  one-cycle misaligned-access pulse
//
// state | meaning
// IDLE  | waiting for a memory instruction in EX
// REQ   | dc_req_valid high, fields frozen until dc_req_ready
// WAIT  | load accepted, waiting for dc_resp_valid
// DONE  | access complete, one cycle so EX can advance without re-issue
// ---------------------------------------------------------------------------
module lsu_dcache_port
  import lsu_dcache_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              EX_LdStFlag,
  input  logic [ADDR_W-1:0] EX_AluData,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        IDEX_LdType,
  input  logic [1:0]        IDEX_StType,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_req_we,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [DATA_W-1:0] dc_req_wdata,
  output logic [3:0]        dc_req_wstrb,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_rdata,
  output logic              lsu_stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              lsu_misalign
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [2:0]        r_ld_type;
  logic [1:0]        r_off;

  logic              w_is_ld;
  logic              w_is_st;
  logic              w_start;
  logic              w_start_aligned;
  logic              w_misalign;
  logic [1:0]        w_st_type;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_ld_data;

  assign w_is_ld   = is_load(IDEX_LdType);
  assign w_is_st   = (IDEX_StType != ST_NONE);
  assign w_st_type = w_is_ld ? ST_NONE : IDEX_StType;

  assign w_start = (r_state == LSU_IDLE) && ex_valid && EX_LdStFlag &&
                   (w_is_ld || w_is_st);
  assign w_start_aligned = w_start && !w_misalign;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_off         (EX_AluData[1:0]),
    .i_ld_type     (IDEX_LdType),
    .i_st_type     (w_st_type),
    .i_st_data     (st_data),
    .o_wdata       (w_wdata),
    .o_wstrb       (w_wstrb),
    .o_misalign    (w_misalign),
    .i_rsp_off     (r_off),
    .i_rsp_ld_type (r_ld_type),
    .i_rdata       (dc_resp_rdata),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: if (w_start_aligned) w_next = LSU_REQ;
      LSU_REQ:  if (dc_req_ready)    w_next = dc_req_we ? LSU_DONE : LSU_WAIT;
      LSU_WAIT: if (dc_resp_valid)   w_next = LSU_DONE;
      LSU_DONE: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  // Stall is low in DONE so EX advances exactly once per access.
  always_comb begin
    lsu_stall = w_start_aligned || (r_state == LSU_REQ) || (r_state == LSU_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_req_valid <= 1'b0;
      dc_req_we    <= 1'b0;
      dc_req_addr  <= '0;
      dc_req_wdata <= '0;
      dc_req_wstrb <= 4'b0000;
      r_ld_type    <= LD_NONE;
      r_off        <= 2'b00;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      lsu_misalign <= 1'b0;
    end else begin
      lsu_misalign <= w_start && w_misalign;
      wb_valid     <= 1'b0;
      if (w_start_aligned) begin
        dc_req_valid <= 1'b1;
        dc_req_we    <= !w_is_ld;
        dc_req_addr  <= {EX_AluData[ADDR_W-1:2], 2'b00};
        dc_req_wdata <= w_wdata;
        dc_req_wstrb <= w_wstrb;
        r_ld_type    <= w_is_ld ? IDEX_LdType : LD_NONE;
        r_off        <= EX_AluData[1:0];
      end else if ((r_state == LSU_REQ) && dc_req_ready) begin
        dc_req_valid <= 1'b0;
      end
      if ((r_state == LSU_WAIT) && dc_resp_valid) begin
        wb_valid <= 1'b1;
        wb_data  <= w_ld_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dcache_port.sv
module tb_lsu_dcache_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        EX_LdStFlag = 1'b0;
  logic [31:0] EX_AluData = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  IDEX_LdType = '0;
  logic [1:0]  IDEX_StType = '0;
  logic        dc_req_valid;
  logic        dc_req_ready = 1'b0;
  logic        dc_req_we;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_wdata;
  logic [3:0]  dc_req_wstrb;
  logic        dc_resp_valid = 1'b0;
  logic [31:0] dc_resp_rdata = '0;
  logic        lsu_stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        lsu_misalign;

  always #5 clk = ~clk;

  lsu_dcache_port #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .EX_LdStFlag   (EX_LdStFlag),
    .EX_AluData    (EX_AluData),
    .st_data       (st_data),
    .IDEX_LdType   (IDEX_LdType),
    .IDEX_StType   (IDEX_StType),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_req_we     (dc_req_we),
    .dc_req_addr   (dc_req_addr),
    .dc_req_wdata  (dc_req_wdata),
    .dc_req_wstrb  (dc_req_wstrb),
    .dc_resp_valid (dc_resp_valid),
    .dc_resp_rdata (dc_resp_rdata),
    .lsu_stall     (lsu_stall),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .lsu_misalign  (lsu_misalign)
  );

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    bit          hold;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wb;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [31:0] wb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          stall_cnt = 0;
  vec_t        vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] ld, input logic [1:0] st,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rd, input int dly, input bit hold,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [3:0] e_wstrb, input logic [31:0] e_wb);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.sd = sd; v.rd = rd; v.dly = dly;
    v.hold = hold; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
    v.e_wb = e_wb;
    return v;
  endfunction

  // Scoreboard: request fields are compared every cycle valid is high, which
  // also proves they stay stable while ready is low.
  always @(negedge clk) begin
    if (!rst && dc_req_valid) begin
      if (req_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_req actual=addr %h required=no request", dc_req_addr);
      end else begin
        chk("req_addr",  dc_req_addr,  req_q[0].addr);
        chk("req_we",    {31'd0, dc_req_we}, {31'd0, req_q[0].we});
        chk("req_wdata", dc_req_wdata, req_q[0].wdata);
        chk("req_wstrb", {28'd0, dc_req_wstrb}, {28'd0, req_q[0].wstrb});
        if (dc_req_ready) void'(req_q.pop_front());
      end
    end
    if (lsu_stall) stall_cnt++;
    if (!rst && wb_valid) begin
      if (wb_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_wb actual=%h required=no wb_valid", wb_data);
      end else begin
        chk("wb_data", wb_data, wb_q.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v);
    req_t r;
    bit   is_ld;
    is_ld = (v.ld >= 3'd1) && (v.ld <= 3'd5);
    ex_valid = 1'b1; EX_LdStFlag = 1'b1;
    IDEX_LdType = v.ld; IDEX_StType = v.st; EX_AluData = v.addr; st_data = v.sd;
    r.addr = v.e_addr; r.we = !is_ld; r.wdata = v.e_wdata; r.wstrb = v.e_wstrb;
    req_q.push_back(r);
    if (is_ld) wb_q.push_back(v.e_wb);
    stall_cnt = 0;
    @(posedge clk); #1;
    if (!v.hold) begin ex_valid = 1'b0; EX_LdStFlag = 1'b0; end
    chk("req_valid_T1", {31'd0, dc_req_valid}, 32'd1);
    repeat (v.dly) begin @(posedge clk); #1; end
    dc_req_ready = 1'b1;
    @(posedge clk); #1;
    dc_req_ready = 1'b0;
    if (is_ld) begin
      chk("stall_in_wait", {31'd0, lsu_stall}, 32'd1);
      dc_resp_valid = 1'b1; dc_resp_rdata = v.rd;
      @(posedge clk); #1;
      dc_resp_valid = 1'b0;
      chk("wb_valid_done", {31'd0, wb_valid}, 32'd1);
    end else begin
      // Stray response in DONE must be ignored.
      dc_resp_valid = 1'b1; dc_resp_rdata = v.rd;
    end
    chk("req_valid_dropped", {31'd0, dc_req_valid}, 32'd0);
    chk("stall_low_done", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    dc_resp_valid = 1'b0;
    chk("stall_cycles", stall_cnt, is_ld ? v.dly + 3 : v.dly + 2);
  endtask

  task automatic run_mis(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr);
    ex_valid = 1'b1; EX_LdStFlag = 1'b1;
    IDEX_LdType = ld; IDEX_StType = st; EX_AluData = addr; st_data = 32'h1234_5678;
    #1;
    chk("mis_stall_T0", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; EX_LdStFlag = 1'b0;
    chk("mis_pulse", {31'd0, lsu_misalign}, 32'd1);
    chk("mis_no_req", {31'd0, dc_req_valid}, 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse_end", {31'd0, lsu_misalign}, 32'd0);
    chk("mis_stall", {31'd0, lsu_stall}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(3'd3, 2'd0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF);
    vecs[1]  = mk(3'd1, 2'd0, 32'h1003, 32'h0, 32'h80112233, 0, 0, 32'h1000, 32'h0, 4'h0, 32'hFFFFFF80);
    vecs[2]  = mk(3'd4, 2'd0, 32'h1003, 32'h0, 32'h80112233, 0, 0, 32'h1000, 32'h0, 4'h0, 32'h00000080);
    vecs[3]  = mk(3'd5, 2'd0, 32'h1002, 32'h0, 32'h80112233, 0, 0, 32'h1000, 32'h0, 4'h0, 32'h00008011);
    vecs[4]  = mk(3'd2, 2'd0, 32'h1002, 32'h0, 32'h80112233, 1, 0, 32'h1000, 32'h0, 4'h0, 32'hFFFF8011);
    vecs[5]  = mk(3'd1, 2'd0, 32'h1001, 32'h0, 32'h80112233, 0, 0, 32'h1000, 32'h0, 4'h0, 32'h00000022);
    vecs[6]  = mk(3'd0, 2'd1, 32'h2001, 32'h000000A5, 32'h0, 3, 0, 32'h2000, 32'hA5A5A5A5, 4'b0010, 32'h0);
    vecs[7]  = mk(3'd0, 2'd2, 32'h2002, 32'h1234BEEF, 32'h0, 0, 0, 32'h2000, 32'hBEEFBEEF, 4'b1100, 32'h0);
    vecs[8]  = mk(3'd0, 2'd3, 32'h3004, 32'hCAFEF00D, 32'h0, 0, 0, 32'h3004, 32'hCAFEF00D, 4'b1111, 32'h0);
    vecs[9]  = mk(3'd3, 2'd0, 32'h4008, 32'h0, 32'h12345678, 1, 1, 32'h4008, 32'h0, 4'h0, 32'h12345678);
    vecs[10] = mk(3'd0, 2'd3, 32'h400C, 32'h0BADC0DE, 32'h0, 0, 1, 32'h400C, 32'h0BADC0DE, 4'b1111, 32'h0);
    vecs[11] = mk(3'd2, 2'd0, 32'h0000, 32'h0, 32'h0000FFFE, 0, 0, 32'h0000, 32'h0, 4'h0, 32'hFFFFFFFE);
    vecs[12] = mk(3'd3, 2'd3, 32'h5000, 32'hFFFFFFFF, 32'h0BADF00D, 0, 0, 32'h5000, 32'h0, 4'h0, 32'h0BADF00D);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, dc_req_valid}, 32'd0);
    chk("rst_req_we",    {31'd0, dc_req_we}, 32'd0);
    chk("rst_req_addr",  dc_req_addr, 32'd0);
    chk("rst_req_wdata", dc_req_wdata, 32'd0);
    chk("rst_req_wstrb", {28'd0, dc_req_wstrb}, 32'd0);
    chk("rst_wb_valid",  {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data",   wb_data, 32'd0);
    chk("rst_misalign",  {31'd0, lsu_misalign}, 32'd0);
    chk("rst_stall",     {31'd0, lsu_stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);
    ex_valid = 1'b0; EX_LdStFlag = 1'b0;
    @(posedge clk); #1;
    chk("wb_data_holds", wb_data, 32'h0BADF00D);

    run_mis(3'd0, 2'd2, 32'h2003);
    run_mis(3'd3, 2'd0, 32'h1002);
    run_mis(3'd0, 2'd3, 32'h2001);
    run_mis(3'd5, 2'd0, 32'h1001);
    run_mis(3'd2, 2'd0, 32'h1003);

    // Type codes 6/7 and a non-memory or invalid slot must not start.
    ex_valid = 1'b1; EX_LdStFlag = 1'b1; IDEX_LdType = 3'd6; IDEX_StType = 2'd0;
    EX_AluData = 32'h100; #1;
    chk("ld6_no_stall", {31'd0, lsu_stall}, 32'd0);
    IDEX_LdType = 3'd3; EX_LdStFlag = 1'b0; #1;
    chk("noflag_no_stall", {31'd0, lsu_stall}, 32'd0);
    EX_LdStFlag = 1'b1; ex_valid = 1'b0; #1;
    chk("noexv_no_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    chk("noop_no_req", {31'd0, dc_req_valid}, 32'd0);
    EX_LdStFlag = 1'b0; IDEX_LdType = 3'd0;

    // Reset while waiting for a load response; late response ignored.
    begin
      req_t r;
      r.addr = 32'h6000; r.we = 1'b0; r.wdata = 32'h0; r.wstrb = 4'h0;
      req_q.push_back(r);
    end
    ex_valid = 1'b1; EX_LdStFlag = 1'b1; IDEX_LdType = 3'd3; IDEX_StType = 2'd0;
    EX_AluData = 32'h6000;
    @(posedge clk); #1;
    ex_valid = 1'b0; EX_LdStFlag = 1'b0;
    dc_req_ready = 1'b1;
    @(posedge clk); #1;
    dc_req_ready = 1'b0;
    chk("wait_stall", {31'd0, lsu_stall}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_req_valid", {31'd0, dc_req_valid}, 32'd0);
    chk("rst_mid_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dc_resp_valid = 1'b1; dc_resp_rdata = 32'h55555555;
    @(posedge clk); #1;
    dc_resp_valid = 1'b0;
    chk("late_resp_no_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("late_resp_no_wb2", {31'd0, wb_valid}, 32'd0);
    run_vec(vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("wb_q_empty", wb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dcache_port.md
Name: lsu_dcache_port

Overview:
- Memory-side consumer of the EX stage result bus.
- Takes the effective address (EX_AluData), store data and load/store type for a memory instruction flagged by EX_LdStFlag.
- Runs a valid/ready request and response handshake to the dcache, packs store bytes, and extracts and sign/zero-extends load data.
- Holds the pipeline with a stall signal until the access completes. Sits between the EX stage and the MEM/WB register.

Parameters:
- DATA_W, 32, data path width (`DATA_WIDTH).
- ADDR_W, 32, address width (`ADDR_WIDTH).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  a valid instruction occupies EX this cycle.
- EX_LdStFlag  in  1  EX instruction is a load or store.
- EX_AluData  in  ADDR_W  effective address (low ADDR_W bits of the ALU result).
- st_data  in  DATA_W  forwarded rs2 store data.
- IDEX_LdType  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU (6/7 treated as none).
- IDEX_StType  in  2  0 none, 1 SB, 2 SH, 3 SW.
- dc_req_valid  out  1  dcache request valid.
- dc_req_ready  in  1  dcache accepts the request.
- dc_req_we  out  1  1 = store.
- dc_req_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- dc_req_wdata  out  DATA_W  lane-replicated store data.
- dc_req_wstrb  out  4  byte enables.
- dc_resp_valid  in  1  load data valid (loads only).
- dc_resp_rdata  in  DATA_W  returned word.
- lsu_stall  out  1  hold IF/ID/EX.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_data  out  DATA_W  extended load result.
- lsu_misalign  out  1  one-cycle pulse: misaligned access, no request issued.

Behaviour:
- Reset (async, rst=1): state IDLE, and every registered output is 0: dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb, wb_valid, wb_data, lsu_misalign. lsu_stall is 0 at reset because it is derived from IDLE with no start.
- start condition: state==IDLE && ex_valid && EX_LdStFlag && (LdType in 1..5 or StType!=0). LdType takes priority if both types are nonzero.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - lsu_misalign pulses the next cycle.
  - No request is issued; state stays IDLE.
  - lsu_stall is not asserted.
- On an aligned start:
  - Latch addr, type, packed wdata and wstrb.
  - Go to REQ and assert dc_req_valid from the next cycle.
- States:
  - IDLE: waits for start.
  - REQ: dc_req_valid=1; all request fields held stable until dc_req_ready. On ready, a store goes to DONE and a load goes to WAIT. dc_req_valid drops the cycle after the handshake.
  - WAIT: on dc_resp_valid, register the extracted data into wb_data, pulse wb_valid, go to DONE.
  - DONE: one cycle, then IDLE. No start is evaluated in DONE, so the completed instruction is never re-issued.
- lsu_stall = start_aligned | (state==REQ) | (state==WAIT). It is combinational and low in DONE, so EX advances at the end of the DONE cycle.
- Store packing (lane offset o=addr[1:0]):
  - SB: wdata={4{st_data[7:0]}}, wstrb=4'b0001<<o.
  - SH: wdata={2{st_data[15:0]}}, wstrb=4'b0011<<{o[1],1'b0}.
  - SW: wdata=st_data, wstrb=4'b1111.
- Load extract:
  - Shift rdata right by 8*o.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Latency, best case (ready at first REQ cycle, response next cycle):
  - Load: start at T0, handshake T1, response T2, wb_valid at T3, lsu_stall high T0–T2.
  - Store: stall high T0–T1, DONE at T2.
- Boundaries:
  - dc_resp_valid outside WAIT is ignored.
  - Ready held low indefinitely keeps REQ and the stall asserted with no timeout.
  - Reset mid-REQ/WAIT immediately drops dc_req_valid and lsu_stall; a late response is ignored.
  - wb_data holds its last value when wb_valid=0.

Decomposition:
- Shared defines header holds:
  - LD_TYPE/ST_TYPE encodings (LD_NONE..LD_LHU, ST_NONE..ST_SW);
  - LSU state encodings (IDLE, REQ, WAIT, DONE, 2 bits).
- One combinational sub-module, lsu_align: store packing (wdata/wstrb), load extraction/extension, and the misalign check. The FSM and registers stay in lsu_dcache_port.

Test Plan:
- LW at addr 0x1000, ready immediate, resp rdata 0xDEADBEEF next cycle -> req addr 0x1000, we=0; wb_valid at T3 with wb_data 0xDEADBEEF; stall high exactly T0–T2.
- LB at addr 0x1003, rdata 0x80112233 -> wb_data 0xFFFFFF80; LBU same access -> 0x00000080; LHU at 0x1002 -> 0x00008011.
- SB st_data 0x000000A5 at 0x2001, ready held low 3 cycles -> wdata 0xA5A5A5A5, wstrb 0010, all fields stable during the wait; stall drops the cycle after the handshake cycle; no wb_valid.
- SH at 0x2003 -> lsu_misalign pulse one cycle, dc_req_valid never asserted, lsu_stall 0.
- Reset asserted while in WAIT, then dc_resp_valid pulses -> dc_req_valid/lsu_stall 0 immediately, no wb_valid, next LW proceeds normally.
- Back-to-back LW/SW with EX_LdStFlag held high through the DONE cycle -> exactly one request per instruction, none issued from DONE.
